ace_snoop_resp_collector: RTL and testbench



---
 rtl/ace_snoop_pkg.sv | 26 ++
 rtl/ace_snoop_resp_collector_if.sv | 42 ++++
 rtl/ace_snoop_resp_collector_prio_onehot_sel.sv | 12 +
 rtl/ace_snoop_resp_collector.sv | 175 +++++++++++++++++
 tb/tb_ace_snoop_resp_collector.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ace_snoop_pkg.sv
// Shared constants and types for the ACE snoop response collector.
// CRRESP bit positions, FSM state encoding and the merged-result flag struct.
package ace_snoop_pkg;

  localparam int CR_DT  = 0;  // DataTransfer
  localparam int CR_ERR = 1;  // Error
  localparam int CR_PD  = 2;  // PassDirty
  localparam int CR_IS  = 3;  // IsShared
  localparam int CR_WU  = 4;  // WasUnique
  localparam int CR_W   = 5;
  localparam int SEL_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic hit;
    logic dirty;
    logic shared;
    logic error;
  } snoop_flags_t;

endpackage

// File: rtl/ace_snoop_resp_collector_if.sv
// Snoop request, AC/CR broadcast and merged-result signals of the collector.
// slave = collector side, master = coherency controller plus snooped masters.
interface ace_snoop_resp_collector_if
  import ace_snoop_pkg::*;
#(
  parameter int NUM_MASTERS = 8,
  parameter int ADDR_WIDTH  = 32
);
  logic                        snoop_req_valid;
  logic                        snoop_req_ready;
  logic [ADDR_WIDTH-1:0]       snoop_req_addr;
  logic [2:0]                  snoop_req_src;
  logic [NUM_MASTERS-1:0]      ac_valid;
  logic [NUM_MASTERS-1:0]      ac_ready;
  logic [ADDR_WIDTH-1:0]       ac_addr;
  logic [NUM_MASTERS-1:0]      cr_valid;
  logic [NUM_MASTERS-1:0]      cr_ready;
  logic [CR_W*NUM_MASTERS-1:0] cr_resp;
  logic [SEL_W-1:0]            mux_sel;
  logic                        result_valid;
  logic                        result_ready;
  logic                        result_hit;
  logic                        result_dirty;
  logic                        result_shared;
  logic                        result_error;
  logic                        timeout;

  modport slave (
    input  snoop_req_valid, snoop_req_addr, snoop_req_src, ac_ready, cr_valid, cr_resp,
           result_ready,
    output snoop_req_ready, ac_valid, ac_addr, cr_ready, mux_sel, result_valid, result_hit,
           result_dirty, result_shared, result_error, timeout
  );

  modport master (
    output snoop_req_valid, snoop_req_addr, snoop_req_src, ac_ready, cr_valid, cr_resp,
           result_ready,
    input  snoop_req_ready, ac_valid, ac_addr, cr_ready, mux_sel, result_valid, result_hit,
           result_dirty, result_shared, result_error, timeout
  );

endinterface

// File: rtl/ace_snoop_resp_collector_prio_onehot_sel.sv
// Lowest-index-first one-hot picker: gnt has only the least significant set bit of req.
module prio_onehot_sel #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  // Two's complement isolates the lowest set bit.
  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/ace_snoop_resp_collector.sv
// Broadcasts a snoop to all masters but the requester, merges CR responses, picks a data source.
// Optional response timeout enabled by defining SNOOP_TIMEOUT_EN.
module ace_snoop_resp_collector
  import ace_snoop_pkg::*;
#(
  parameter int NUM_MASTERS    = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                       clk,
  input logic                       rst,
  ace_snoop_resp_collector_if.slave sif
);

  localparam int NM = NUM_MASTERS;

  state_e                st_q, st_d;
  logic [NM-1:0]         ac_pend_q, ac_pend_d, cr_pend_q, cr_pend_d;
  logic [NM-1:0]         cand_q, cand_d, req_mask, ac_hs, cr_hs, cr_rdy, sel;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  snoop_flags_t          acc_q, acc_d, res_q;
  logic [SEL_W-1:0]      mux_q, mux_d;
  logic                  rv_q, rv_d, done_ent;

  // CR acceptance only after the master's AC handshake has completed in an earlier cycle.
  assign cr_rdy = cr_pend_q & ~ac_pend_q;
  assign ac_hs  = ac_pend_q & sif.ac_ready;
  assign cr_hs  = cr_rdy & sif.cr_valid;

  prio_onehot_sel #(.W(NM)) u_sel (.req(cand_d), .gnt(sel));

  always_comb begin
    mux_d = '0;
    mux_d[NM-1:0] = sel;
  end

`ifdef SNOOP_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
  logic          tmo_hit, tmo_fire, to_q;

  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !(|ac_hs) && !(|cr_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      to_q <= tmo_fire;
      if (st_q != ST_ACTIVE || |ac_hs || |cr_hs) cnt_q <= '0;
      else                                       cnt_q <= cnt_q + CW'(1);
    end
  end

  assign sif.timeout = to_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign sif.timeout = 1'b0;
`endif

  always_comb begin
    st_d      = st_q;
    ac_pend_d = ac_pend_q;
    cr_pend_d = cr_pend_q;
    cand_d    = cand_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    rv_d      = rv_q;
    done_ent  = 1'b0;
`ifdef SNOOP_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif
    req_mask  = '0;
    for (int i = 0; i < NM; i++) req_mask[i] = (int'(sif.snoop_req_src) != i);

    case (st_q)
      ST_IDLE: begin
        if (sif.snoop_req_valid) begin
          addr_d    = sif.snoop_req_addr;
          ac_pend_d = req_mask;
          cr_pend_d = req_mask;
          cand_d    = '0;
          acc_d     = '0;
          if (req_mask == '0) begin
            st_d     = ST_DONE;
            done_ent = 1'b1;
          end else begin
            st_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        ac_pend_d = ac_pend_q & ~ac_hs;
        cr_pend_d = cr_pend_q & ~cr_hs;
        for (int i = 0; i < NM; i++) begin
          if (cr_hs[i]) begin
            acc_d.hit    = acc_d.hit    | (sif.cr_resp[CR_W*i+CR_DT] & ~sif.cr_resp[CR_W*i+CR_ERR]);
            acc_d.dirty  = acc_d.dirty  | sif.cr_resp[CR_W*i+CR_PD];
            acc_d.shared = acc_d.shared | sif.cr_resp[CR_W*i+CR_IS];
            acc_d.error  = acc_d.error  | sif.cr_resp[CR_W*i+CR_ERR];
            cand_d[i]    = sif.cr_resp[CR_W*i+CR_DT] & ~sif.cr_resp[CR_W*i+CR_ERR];
          end
        end
        if (cr_pend_d == '0) begin
          st_d     = ST_DONE;
          done_ent = 1'b1;
        end
`ifdef SNOOP_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_fire    = 1'b1;
          acc_d.error = 1'b1;
          ac_pend_d   = '0;
          cr_pend_d   = '0;
          st_d        = ST_DONE;
          done_ent    = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        if (sif.result_ready) begin
          st_d = ST_IDLE;
          rv_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (done_ent) rv_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      ac_pend_q <= '0;
      cr_pend_q <= '0;
      cand_q    <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      rv_q      <= 1'b0;
      res_q     <= '0;
      mux_q     <= '0;
    end else begin
      st_q      <= st_d;
      ac_pend_q <= ac_pend_d;
      cr_pend_q <= cr_pend_d;
      cand_q    <= cand_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      rv_q      <= rv_d;
      // Result and select hold until the next completion, even across IDLE.
      if (done_ent) begin
        res_q <= acc_d;
        mux_q <= mux_d;
      end
    end
  end

  logic unused_wu;
  always_comb begin
    unused_wu = 1'b0;
    for (int i = 0; i < NM; i++) unused_wu = unused_wu ^ sif.cr_resp[CR_W*i+CR_WU];
  end

  assign sif.snoop_req_ready = (st_q == ST_IDLE);
  assign sif.ac_valid        = ac_pend_q;
  assign sif.ac_addr         = addr_q;
  assign sif.cr_ready        = cr_rdy;
  assign sif.mux_sel         = mux_q;
  assign sif.result_valid    = rv_q;
  assign sif.result_hit      = res_q.hit;
  assign sif.result_dirty    = res_q.dirty;
  assign sif.result_shared   = res_q.shared;
  assign sif.result_error    = res_q.error;

endmodule

// File: tb/tb_ace_snoop_resp_collector.sv
// Randomized bench for ace_snoop_resp_collector with a transaction-level reference model.
// Timeout scenario is exercised when SNOOP_TIMEOUT_EN is defined.
module tb_ace_snoop_resp_collector;

  localparam int NM  = 8;
  localparam int TMO = 16;

  logic clk, rst;
  int   n_chk, n_fail;

  // Per-transaction configuration consumed by run_snoop and ref_model.
  int          t_src, t_rr, t_silent, t_lat;
  logic [31:0] t_addr;
  logic [4:0]  t_resp [NM];
  int          t_acd  [NM];
  int          t_crd  [NM];
  bit          t_early[NM];

  ace_snoop_resp_collector_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(32)) sif ();

  ace_snoop_resp_collector #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sif(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Merge rules applied to the snooped masters that actually answer.
  function automatic void ref_model(output logic [7:0] m, output logic [3:0] f);
    m = '0;
    f = '0;
    for (int i = 0; i < NM; i++) begin
      if (i == t_src || i == t_silent) continue;
      if (t_resp[i][0] && !t_resp[i][1]) begin
        f[3] = 1'b1;
        if (m == 8'h00) m = 8'(1 << i);
      end
      if (t_resp[i][2]) f[2] = 1'b1;
      if (t_resp[i][3]) f[1] = 1'b1;
      if (t_resp[i][1]) f[0] = 1'b1;
    end
    if (t_silent >= 0) f[0] = 1'b1;
  endfunction

  task automatic set_defaults();
    t_src = 0; t_rr = 0; t_silent = -1; t_lat = -1; t_addr = $urandom;
    for (int i = 0; i < NM; i++) begin
      t_resp[i] = '0; t_acd[i] = 0; t_crd[i] = 0; t_early[i] = 1'b0;
    end
  endtask

  task automatic run_snoop(input string tag);
    logic [7:0] exp_mask, ac_done, hs_ac, hs_cr, cr_once, exp_once, exp_mux;
    logic [3:0] exp_f;
    int acw[NM], crw[NM], crn[NM];
    int res_cyc, last_hs, viol, hold_bad;
    for (int i = 0; i < NM; i++) begin
      exp_mask[i] = (i != t_src);
      acw[i] = 0; crw[i] = 0; crn[i] = 0;
    end
    ac_done = '0; hs_ac = '0; hs_cr = '0;
    res_cyc = -1; last_hs = 0; viol = 0; hold_bad = 0;
    ref_model(exp_mux, exp_f);

    @(negedge clk);
    chk({tag, "_req_ready"}, sif.snoop_req_ready, 1'b1);
    sif.snoop_req_valid = 1'b1;
    sif.snoop_req_addr  = t_addr;
    sif.snoop_req_src   = 3'(t_src);
    sif.ac_ready = 8'($urandom);
    sif.cr_valid = 8'($urandom);

    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      sif.snoop_req_valid = 1'b0;
      for (int i = 0; i < NM; i++) begin
        if (hs_ac[i]) ac_done[i] = 1'b1;
        if (hs_cr[i]) crn[i]++;
      end
      if ((hs_ac | hs_cr) != 8'h00) last_hs = cyc - 1;
      if (cyc == 1) begin
        chk({tag, "_ac_valid"}, sif.ac_valid, exp_mask);
        chk({tag, "_ac_addr"}, sif.ac_addr, t_addr);
      end
      if (sif.result_valid) begin
        res_cyc = cyc;
        break;
      end
      for (int i = 0; i < NM; i++) begin
        if (sif.cr_ready[i] && !ac_done[i]) viol++;
        if (sif.ac_valid[i] && !exp_mask[i]) viol++;
        if (!exp_mask[i]) begin
          sif.ac_ready[i] = 1'($urandom);
          sif.cr_valid[i] = 1'($urandom);
          sif.cr_resp[5*i +: 5] = 5'($urandom);
        end else begin
          if (!ac_done[i] && sif.ac_valid[i]) acw[i]++;
          if (ac_done[i] && crn[i] == 0) crw[i]++;
          sif.ac_ready[i] = sif.ac_valid[i] && !ac_done[i] && (acw[i] > t_acd[i]);
          sif.cr_valid[i] = (crn[i] == 0) && (i != t_silent) &&
                            ((ac_done[i] && crw[i] > t_crd[i]) || t_early[i]);
          sif.cr_resp[5*i +: 5] = sif.cr_valid[i] ? t_resp[i] : 5'($urandom);
        end
      end
      hs_ac = sif.ac_valid & sif.ac_ready;
      hs_cr = sif.cr_ready & sif.cr_valid;
    end
    sif.ac_ready = '0;
    sif.cr_valid = '0;

    if (res_cyc < 0) begin
      chk({tag, "_result_bound"}, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end

    for (int i = 0; i < NM; i++) begin
      cr_once[i]  = (crn[i] == 1);
      exp_once[i] = exp_mask[i] && (i != t_silent);
    end
    chk({tag, "_mux_sel"}, sif.mux_sel, exp_mux);
    chk({tag, "_flags"}, {sif.result_hit, sif.result_dirty, sif.result_shared, sif.result_error}, exp_f);
    chk({tag, "_cr_once"}, cr_once, exp_once);
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
    chk({tag, "_timeout"}, sif.timeout, t_silent >= 0);
    if (t_lat >= 0)    chk({tag, "_latency"}, 32'(res_cyc), 32'(t_lat));
    if (t_silent >= 0) chk({tag, "_tmo_latency"}, 32'(res_cyc), 32'(last_hs + TMO + 1));

    for (int r = 0; r < t_rr; r++) begin
      @(negedge clk);
      if (!sif.result_valid || sif.snoop_req_ready || sif.timeout || sif.mux_sel != exp_mux ||
          {sif.result_hit, sif.result_dirty, sif.result_shared, sif.result_error} != exp_f)
        hold_bad++;
    end
    if (t_rr > 0) chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
    sif.result_ready = 1'b1;
    @(negedge clk);
    sif.result_ready = 1'b0;
    chk({tag, "_back_idle"}, {sif.result_valid, sif.snoop_req_ready, sif.mux_sel}, {2'b01, exp_mux});
  endtask

  task automatic reset_mid();
    @(negedge clk);
    chk("rst_pre_mux", sif.mux_sel, 8'h20);
    sif.snoop_req_valid = 1'b1;
    sif.snoop_req_src   = 3'd0;
    sif.snoop_req_addr  = $urandom;
    sif.ac_ready = '0;
    sif.cr_valid = '0;
    @(negedge clk);
    sif.snoop_req_valid = 1'b0;
    chk("rst_active_ac_valid", sif.ac_valid, 8'hFE);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ac_valid", sif.ac_valid, 8'h00);
    chk("rst_mid_mux", sif.mux_sel, 8'h00);
    chk("rst_mid_idle", {sif.snoop_req_ready, sif.result_valid, sif.cr_ready}, {2'b10, 8'h00});
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    sif.snoop_req_valid = 1'b0; sif.snoop_req_addr = '0; sif.snoop_req_src = '0;
    sif.ac_ready = '0; sif.cr_valid = '0; sif.cr_resp = '0; sif.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ac", {sif.ac_valid, sif.cr_ready, sif.ac_addr}, '0);
    chk("reset_result", {sif.mux_sel, sif.result_valid, sif.result_hit, sif.result_dirty,
                         sif.result_shared, sif.result_error, sif.timeout}, '0);
    chk("reset_ready", sif.snoop_req_ready, 1'b1);
    rst = 1'b0;

    set_defaults(); t_src = 2; t_resp[5] = 5'b00101; t_lat = 3;
    run_snoop("pass_dirty");

    reset_mid();

    set_defaults(); t_src = 7; t_acd[6] = 2;
    t_resp[0] = 5'b00011; t_resp[1] = 5'b00001; t_resp[6] = 5'b00001;
    run_snoop("lowest_idx");

    set_defaults(); t_src = 0; t_early[3] = 1'b1; t_acd[3] = 4; t_resp[3] = 5'b01001;
    run_snoop("early_cr");

    set_defaults(); t_src = 5; t_resp[2] = 5'b01000; t_rr = 10;
    run_snoop("no_data");

`ifdef SNOOP_TIMEOUT_EN
    set_defaults(); t_src = 0; t_silent = 4; t_rr = 1;
    for (int i = 0; i < NM; i++) begin
      t_resp[i] = 5'($urandom);
      t_acd[i]  = $urandom_range(0, 3);
    end
    run_snoop("timeout");
`endif

    for (int n = 0; n < 40; n++) begin
      set_defaults();
      t_src = $urandom_range(0, NM - 1);
      t_rr  = $urandom_range(0, 3);
      for (int i = 0; i < NM; i++) begin
        t_resp[i]  = 5'($urandom);
        t_acd[i]   = $urandom_range(0, 3);
        t_crd[i]   = $urandom_range(0, 3);
        t_early[i] = ($urandom_range(0, 3) == 0);
      end
      run_snoop("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
